hilo_md_ctrl: RTL

- Sequencer for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs multi-cycle multiply and divide.
- Stalls the pipeline while busy; produces the single write-enable/data pair that drives the hilo register.
- Sits between the execute-stage decode/ALU and the hilo register. Sole writer of hilo.

---
 rtl/hilo_md_ctrl_pkg.sv | 23 ++
 rtl/md_div_iter.sv | 75 +++++++
 rtl/hilo_md_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hilo_md_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package hilo_md_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed fixup applied
// combinationally on the final iteration so the result is ready with done_o.
module md_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         sgn_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] q_o,
  output logic [W-1:0] r_o
);

  localparam int CW = $clog2(W);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvd_q, dvs_q, rem_q;
  logic          negq_q, negr_q;

  logic [W:0]    rem_sh, diff;
  logic          ge;
  logic [W-1:0]  rem_nxt, quo_nxt;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // The extra remainder bit keeps the compare exact for unsigned divisors >= 2^(W-1).
  always_comb begin
    rem_sh  = {rem_q, dvd_q[W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    ge      = ~diff[W];
    rem_nxt = ge ? diff[W-1:0] : rem_sh[W-1:0];
    quo_nxt = {dvd_q[W-2:0], ge};
  end

  assign done_o = run_q && (cnt_q == '0);
  assign q_o    = neg_if(quo_nxt, negq_q);
  assign r_o    = neg_if(rem_nxt, negr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= CW'(W - 1);
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      dvd_q  <= mag(a_i, sgn_i);
      dvs_q  <= mag(b_i, sgn_i);
      rem_q  <= '0;
      negq_q <= sgn_i && (a_i[W-1] ^ b_i[W-1]);
      negr_q <= sgn_i && a_i[W-1];
    end else if (run_q) begin
      dvd_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO sequencer: sole writer of the hilo register, runs multi-cycle
// multiply/divide and stalls the pipeline until the result is written.
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_BITS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic [63:0] hilo_cur,
  output logic        stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy
);

  localparam int MCW = $clog2(MUL_CYCLES) + 1;

  md_state_e        state_q, state_d;
  logic [MCW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_sgn_q, mul_sgn_d;
  logic [63:0]      res_q, res_d;

  logic             div_start, div_done;
  logic [XLEN-1:0]  div_q, div_r;

  function automatic logic [63:0] mul_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  md_div_iter #(.W(DIV_BITS)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .sgn_i   (op == MD_DIV),
    .a_i     (src_a),
    .b_i     (src_b),
    .done_o  (div_done),
    .q_o     (div_q),
    .r_o     (div_r)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_sgn_d  = mul_sgn_q;
    res_d      = res_q;
    div_start  = 1'b0;
    stall      = 1'b0;
    hilo_we    = 1'b0;
    hilo_wdata = '0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MTHI: begin
                hilo_we    = 1'b1;
                hilo_wdata = {src_a, hilo_cur[31:0]};
              end
              MD_MTLO: begin
                hilo_we    = 1'b1;
                hilo_wdata = {hilo_cur[63:32], src_a};
              end
              MD_MULT, MD_MULTU: begin
                stall     = 1'b1;
                mul_a_d   = src_a;
                mul_b_d   = src_b;
                mul_sgn_d = (op == MD_MULT);
                cnt_d     = MCW'(MUL_CYCLES - 2);
                state_d   = ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                stall = 1'b1;
                if (src_b == '0) begin
                  res_d   = {src_a, 32'hFFFF_FFFF};
                  state_d = ST_DONE;
                end else begin
                  div_start = 1'b1;
                  state_d   = ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        // Product re-registered every MUL cycle; the last capture feeds DONE.
        ST_MUL: begin
          stall = 1'b1;
          res_d = mul_prod(mul_a_q, mul_b_q, mul_sgn_q);
          if (cnt_q <= MCW'(1)) state_d = ST_DONE;
          else                  cnt_d   = cnt_q - MCW'(1);
        end
        ST_DIV: begin
          stall = 1'b1;
          if (div_done) begin
            res_d   = {div_r, div_q};
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          hilo_we    = 1'b1;
          hilo_wdata = res_q;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sgn_q <= mul_sgn_d;
      res_q     <= res_d;
    end
  end

endmodule
